// File: rtl/if_unit.sv
// Instruction fetch stage: drives instruction memory and fills the IF/ID register.
// Optional feature: define IF_HALT_EN to add a HALT state and the halted port.
// When enabled, accepting an opcode 4'hF instruction into IF/ID stops fetch.
module if_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    output logic [15:0] instr_out,
    output logic [15:0] PC_out,
    output logic        valid_out
`ifdef IF_HALT_EN
    ,
    output logic        halted
`endif
);

    localparam int unsigned AW = 16;
    localparam int unsigned IW = 16;

`ifdef IF_HALT_EN
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        HALT  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1
    } state_t;
`endif

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [IW-1:0] instr_q, instr_d;
    logic [AW-1:0] pc_out_q, pc_out_d;
    logic          valid_q, valid_d;
    logic [IW-1:0] hold_instr_q, hold_instr_d;
    logic [AW-1:0] hold_pc_q, hold_pc_d;
    logic [AW-1:0] pc_inc;
`ifdef IF_HALT_EN
    logic          halted_q, halted_d;
`endif

    // Request is issued only while fetching; the address is always the current pc.
    assign imem_req  = (state_q == FETCH);
    assign imem_addr = pc_q;
    assign pc_inc    = AW'(pc_q + AW'(1));

    assign instr_out = instr_q;
    assign PC_out    = pc_out_q;
    assign valid_out = valid_q;
`ifdef IF_HALT_EN
    assign halted    = halted_q;
`endif

    // Next-state and IF/ID update; priority redirect > flush > stall > fetch.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        pc_out_d     = pc_out_q;
        valid_d      = valid_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;

        if (redirect) begin
            pc_d    = redirect_pc;
            valid_d = 1'b0;
            state_d = FETCH;
        end else if (flush) begin
            valid_d = 1'b0;
`ifdef IF_HALT_EN
            // Halt is left only by reset or redirect.
            if (state_q != HALT) begin
                state_d = FETCH;
            end
`else
            state_d = FETCH;
`endif
        end else begin
            case (state_q)
                FETCH: begin
                    if (stall) begin
                        // Park a returning word so it is not lost while decode is stalled.
                        if (imem_rdy) begin
                            hold_instr_d = imem_data;
                            hold_pc_d    = pc_inc;
                            pc_d         = pc_inc;
                            state_d      = HOLD;
                        end
                    end else if (imem_rdy) begin
                        instr_d  = imem_data;
                        pc_out_d = pc_inc;
                        valid_d  = 1'b1;
                        pc_d     = pc_inc;
`ifdef IF_HALT_EN
                        if (imem_data[15:12] == 4'hF) begin
                            state_d = HALT;
                        end
`endif
                    end else begin
                        valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        instr_d  = hold_instr_q;
                        pc_out_d = hold_pc_q;
                        valid_d  = 1'b1;
                        state_d  = FETCH;
`ifdef IF_HALT_EN
                        if (hold_instr_q[15:12] == 4'hF) begin
                            state_d = HALT;
                        end
`endif
                    end
                end
`ifdef IF_HALT_EN
                HALT: begin
                    valid_d = 1'b0;
                end
`endif
                default: begin
                    state_d = FETCH;
                    valid_d = 1'b0;
                end
            endcase
        end

`ifdef IF_HALT_EN
        halted_d = (state_d == HALT);
`endif
    end

    // State register with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            instr_q      <= IW'(0);
            pc_out_q     <= AW'(0);
            valid_q      <= 1'b0;
            hold_instr_q <= IW'(0);
            hold_pc_q    <= AW'(0);
`ifdef IF_HALT_EN
            halted_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            pc_out_q     <= pc_out_d;
            valid_q      <= valid_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
`ifdef IF_HALT_EN
            halted_q     <= halted_d;
`endif
        end
    end

endmodule

// File: tb/tb_if_unit.sv
// Directed bench for if_unit; instance b runs from RESET_PC=16'hFFFF to cover pc wrap.
module tb_if_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, redirect;
    logic [15:0] redirect_pc;
    logic        imem_req, imem_rdy;
    logic [15:0] imem_addr, imem_data;
    logic [15:0] instr_out, pc_out;
    logic        valid_out;
    logic        hlt_at3;

    logic        b_req, b_valid;
    logic [15:0] b_addr, b_data, b_instr, b_pc_out;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

`ifdef IF_HALT_EN
    logic halted, b_halted;
`endif

    always #5 clk = ~clk;

    // Memory model: word = 16'h1000 + address, optional HLT word at address 3.
    assign imem_data = (hlt_at3 && imem_addr == 16'h0003) ? 16'hF000 : 16'(16'h1000 + imem_addr);
    assign b_data    = 16'(16'h1000 + b_addr);

    if_unit #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdy(imem_rdy), .imem_data(imem_data),
        .instr_out(instr_out), .PC_out(pc_out), .valid_out(valid_out)
`ifdef IF_HALT_EN
        , .halted(halted)
`endif
    );

    if_unit #(.RESET_PC(16'hFFFF)) dut_b (
        .clk(clk), .rst(rst), .stall(1'b0), .flush(1'b0),
        .redirect(1'b0), .redirect_pc(16'h0000),
        .imem_req(b_req), .imem_addr(b_addr),
        .imem_rdy(1'b1), .imem_data(b_data),
        .instr_out(b_instr), .PC_out(b_pc_out), .valid_out(b_valid)
`ifdef IF_HALT_EN
        , .halted(b_halted)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0;
        redirect_pc = 16'h0000; imem_rdy = 1'b0; hlt_at3 = 1'b0;
        #1;
        check_eq("rst_valid", 32'(valid_out), 32'h0);
        check_eq("rst_instr", 32'(instr_out), 32'h0);
        check_eq("rst_pcout", 32'(pc_out), 32'h0);
        check_eq("rst_req", 32'(imem_req), 32'h1);
        check_eq("rst_addr", 32'(imem_addr), 32'h0);
        check_eq("b_rst_addr", 32'(b_addr), 32'hFFFF);
        tick();
        rst = 1'b0;

        // Full-rate fetch from reset.
        imem_rdy = 1'b1;
        tick();
        check_eq("b_instr0", 32'(b_instr), 32'h0FFF);
        check_eq("b_pcout0", 32'(b_pc_out), 32'h0000);
        check_eq("b_valid0", 32'(b_valid), 32'h1);
        check_eq("b_addr_wrap", 32'(b_addr), 32'h0000);
        check_eq("f0_instr", 32'(instr_out), 32'h1000);
        check_eq("f0_pcout", 32'(pc_out), 32'h1);
        check_eq("f0_valid", 32'(valid_out), 32'h1);
        tick();
        check_eq("f1_instr", 32'(instr_out), 32'h1001);
        check_eq("f1_pcout", 32'(pc_out), 32'h2);
        tick();
        check_eq("f2_instr", 32'(instr_out), 32'h1002);
        check_eq("f2_pcout", 32'(pc_out), 32'h3);
        tick();
        tick();
        check_eq("f4_instr", 32'(instr_out), 32'h1004);
        check_eq("pc5_addr", 32'(imem_addr), 32'h5);

        // Stall with data returning at pc=5 for three cycles.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("hold_instr", 32'(instr_out), 32'h1004);
            check_eq("hold_pcout", 32'(pc_out), 32'h5);
            check_eq("hold_req", 32'(imem_req), 32'h0);
        end
        stall = 1'b0;
        tick();
        check_eq("rel_instr", 32'(instr_out), 32'h1005);
        check_eq("rel_pcout", 32'(pc_out), 32'h6);
        check_eq("rel_valid", 32'(valid_out), 32'h1);
        check_eq("rel_addr", 32'(imem_addr), 32'h6);
        check_eq("rel_req", 32'(imem_req), 32'h1);

        // Memory wait at pc=8.
        tick();
        tick();
        check_eq("pc8_addr", 32'(imem_addr), 32'h8);
        imem_rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("wait_valid", 32'(valid_out), 32'h0);
            check_eq("wait_addr", 32'(imem_addr), 32'h8);
            check_eq("wait_instr_kept", 32'(instr_out), 32'h1007);
        end
        imem_rdy = 1'b1;
        tick();
        check_eq("wait_done_instr", 32'(instr_out), 32'h1008);
        check_eq("wait_done_pcout", 32'(pc_out), 32'h9);

        // Redirect wins over stall and discards returned data.
        stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0040;
        tick();
        check_eq("redir_valid", 32'(valid_out), 32'h0);
        check_eq("redir_addr", 32'(imem_addr), 32'h40);
        check_eq("redir_instr", 32'(instr_out), 32'h1008);
        check_eq("redir_req", 32'(imem_req), 32'h1);
        stall = 1'b0; redirect = 1'b0;
        tick();
        check_eq("redir_f_instr", 32'(instr_out), 32'h1040);
        check_eq("redir_f_pcout", 32'(pc_out), 32'h41);

        // Flush in FETCH: bubble, pc unchanged.
        flush = 1'b1;
        tick();
        check_eq("flush_valid", 32'(valid_out), 32'h0);
        check_eq("flush_addr", 32'(imem_addr), 32'h41);
        flush = 1'b0;
        tick();
        check_eq("flush_f_instr", 32'(instr_out), 32'h1041);
        check_eq("flush_f_pcout", 32'(pc_out), 32'h42);

        // Flush in HOLD drops the buffered word; pc stays advanced.
        stall = 1'b1;
        tick();
        check_eq("h2_req", 32'(imem_req), 32'h0);
        flush = 1'b1;
        tick();
        check_eq("hflush_valid", 32'(valid_out), 32'h0);
        check_eq("hflush_req", 32'(imem_req), 32'h1);
        check_eq("hflush_addr", 32'(imem_addr), 32'h43);
        flush = 1'b0; stall = 1'b0;
        tick();
        check_eq("hflush_f_instr", 32'(instr_out), 32'h1043);
        check_eq("hflush_f_pcout", 32'(pc_out), 32'h44);

`ifdef IF_HALT_EN
        // HLT word at pc=3 stops fetch; redirect restarts it.
        hlt_at3 = 1'b1;
        redirect = 1'b1; redirect_pc = 16'h0003;
        tick();
        redirect = 1'b0;
        check_eq("hlt_addr", 32'(imem_addr), 32'h3);
        tick();
        check_eq("hlt_instr", 32'(instr_out), 32'hF000);
        check_eq("hlt_valid", 32'(valid_out), 32'h1);
        check_eq("hlt_pcout", 32'(pc_out), 32'h4);
        check_eq("hlt_halted", 32'(halted), 32'h1);
        check_eq("hlt_req", 32'(imem_req), 32'h0);
        tick();
        check_eq("hlt2_valid", 32'(valid_out), 32'h0);
        check_eq("hlt2_halted", 32'(halted), 32'h1);
        check_eq("hlt2_addr", 32'(imem_addr), 32'h4);
        redirect = 1'b1; redirect_pc = 16'h0010;
        tick();
        redirect = 1'b0;
        check_eq("unhlt_halted", 32'(halted), 32'h0);
        check_eq("unhlt_req", 32'(imem_req), 32'h1);
        check_eq("unhlt_addr", 32'(imem_addr), 32'h10);
        tick();
        check_eq("unhlt_instr", 32'(instr_out), 32'h1010);
        hlt_at3 = 1'b0;
`endif

        // Asynchronous reset mid-transaction.
        imem_rdy = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_addr", 32'(imem_addr), 32'h0);
        check_eq("arst_valid", 32'(valid_out), 32'h0);
        check_eq("arst_instr", 32'(instr_out), 32'h0);
        tick();
        rst = 1'b0;
        imem_rdy = 1'b1;
        tick();
        check_eq("post_rst_instr", 32'(instr_out), 32'h1000);
        check_eq("post_rst_pcout", 32'(pc_out), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
